// File: rtl/vend_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller_if
// Brief    : Dispenser request/acknowledge handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface vend_controller_if;
  logic       disp_req;
  logic [1:0] disp_prod;
  logic       disp_ack;

  modport master (output disp_req, output disp_prod, input disp_ack);
  modport slave  (input disp_req, input disp_prod, output disp_ack);
endinterface
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Brief    : Vending sequencer: button sync, credit, price check, dispense
//            handshake with timeout, and change payout.
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
  parameter int PRICE0      = 2,
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 5,
  parameter int MAX_CREDIT  = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coin,
  input  logic                     go,
  input  logic [1:0]               sel,
  vend_controller_if.master        disp,
  output logic [2:0]               credit,
  output logic                     change_pulse,
  output logic                     coin_reject,
  output logic                     deny,
  output logic                     busy,
  output logic                     error
);

  localparam logic [2:0] c_price0  = 3'(PRICE0);
  localparam logic [2:0] c_price1  = 3'(PRICE1);
  localparam logic [2:0] c_price2  = 3'(PRICE2);
  localparam logic [2:0] c_max     = 3'(MAX_CREDIT);
  localparam logic [7:0] c_timeout = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t     r_state, w_state_n;
  logic       r_coin_s1, r_coin_s2, r_coin_s3;
  logic       r_go_s1, r_go_s2, r_go_s3;
  logic [1:0] r_sel_s1, r_sel_s2;
  logic [7:0] r_cnt, w_cnt_n;
  logic       r_phase, w_phase_n;
  logic [2:0] r_credit, w_credit_n;
  logic       r_disp_req, w_disp_req_n;
  logic [1:0] r_disp_prod, w_disp_prod_n;
  logic       r_change_pulse, w_change_pulse_n;
  logic       r_coin_reject, w_coin_reject_n;
  logic       r_deny, w_deny_n;
  logic       r_busy, w_busy_n;
  logic       r_error, w_error_n;

  logic       w_coin_rise, w_go_rise;
  logic [2:0] w_price;
  logic [3:0] w_restore;

  assign w_coin_rise = r_coin_s2 & ~r_coin_s3;
  assign w_go_rise   = r_go_s2 & ~r_go_s3;
  assign w_restore   = {1'b0, r_credit} + {1'b0, w_price};

  always_comb begin
    w_price = c_price2;
    case (r_disp_prod)
      2'd0:    w_price = c_price0;
      2'd1:    w_price = c_price1;
      default: w_price = c_price2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_coin_s1      <= 1'b0;
      r_coin_s2      <= 1'b0;
      r_coin_s3      <= 1'b0;
      r_go_s1        <= 1'b0;
      r_go_s2        <= 1'b0;
      r_go_s3        <= 1'b0;
      r_sel_s1       <= 2'd0;
      r_sel_s2       <= 2'd0;
      r_cnt          <= 8'd0;
      r_phase        <= 1'b0;
      r_credit       <= 3'd0;
      r_disp_req     <= 1'b0;
      r_disp_prod    <= 2'd0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_deny         <= 1'b0;
      r_busy         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_coin_s1      <= coin;
      r_coin_s2      <= r_coin_s1;
      r_coin_s3      <= r_coin_s2;
      r_go_s1        <= go;
      r_go_s2        <= r_go_s1;
      r_go_s3        <= r_go_s2;
      r_sel_s1       <= sel;
      r_sel_s2       <= r_sel_s1;
      r_cnt          <= w_cnt_n;
      r_phase        <= w_phase_n;
      r_credit       <= w_credit_n;
      r_disp_req     <= w_disp_req_n;
      r_disp_prod    <= w_disp_prod_n;
      r_change_pulse <= w_change_pulse_n;
      r_coin_reject  <= w_coin_reject_n;
      r_deny         <= w_deny_n;
      r_busy         <= w_busy_n;
      r_error        <= w_error_n;
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_cnt_n          = r_cnt;
    w_phase_n        = r_phase;
    w_credit_n       = r_credit;
    w_disp_req_n     = r_disp_req;
    w_disp_prod_n    = r_disp_prod;
    w_change_pulse_n = 1'b0;
    w_coin_reject_n  = 1'b0;
    w_deny_n         = 1'b0;
    w_error_n        = r_error;

    // Coins are only banked in IDLE; everywhere else they bounce.
    if (w_coin_rise && r_state != S_IDLE) w_coin_reject_n = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_go_rise) begin
          if (r_sel_s2 == 2'd3) begin
            w_phase_n = 1'b0;
            w_state_n = S_CHANGE;
          end else begin
            w_disp_prod_n = r_sel_s2;
            w_state_n     = S_CHECK;
          end
        end
        if (w_coin_rise) begin
          if (w_go_rise || r_credit == c_max) w_coin_reject_n = 1'b1;
          else                                w_credit_n      = r_credit + 3'd1;
        end
      end
      S_CHECK: begin
        if (r_credit >= w_price) begin
          w_credit_n   = r_credit - w_price;
          w_disp_req_n = 1'b1;
          w_cnt_n      = 8'd0;
          w_state_n    = S_DISPENSE;
        end else begin
          w_deny_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_DISPENSE: begin
        if (disp.disp_ack) begin
          w_disp_req_n = 1'b0;
          w_phase_n    = 1'b0;
          w_state_n    = (r_credit != 3'd0) ? S_CHANGE : S_IDLE;
        end else if (r_cnt == c_timeout) begin
          // Hand the price back so the customer is not charged for a failed vend.
          w_credit_n   = (w_restore > {1'b0, c_max}) ? c_max : w_restore[2:0];
          w_disp_req_n = 1'b0;
          w_error_n    = 1'b1;
          w_state_n    = S_FAULT;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_CHANGE: begin
        if (r_phase) begin
          w_phase_n = 1'b0;
        end else if (r_credit != 3'd0) begin
          w_change_pulse_n = 1'b1;
          w_credit_n       = r_credit - 3'd1;
          w_phase_n        = 1'b1;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_FAULT: begin
        w_error_n = 1'b1;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    w_busy_n = (w_state_n != S_IDLE);
  end

  assign disp.disp_req  = r_disp_req;
  assign disp.disp_prod = r_disp_prod;
  assign credit         = r_credit;
  assign change_pulse   = r_change_pulse;
  assign coin_reject    = r_coin_reject;
  assign deny           = r_deny;
  assign busy           = r_busy;
  assign error          = r_error;

endmodule
`default_nettype wire
